// File: rtl/lc3_pkg.sv
// lc3_pkg: shared state encoding, nzp field position and reset PC for the LC-3 branch path
package lc3_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    TAKE = 2'd2,
    FIN  = 2'd3
  } br_state_e;
  localparam int NZP_HI = 11;
  localparam int NZP_LO = 9;
  localparam logic [15:0] RESET_PC_DEF = 16'h3000;
endpackage

// File: rtl/br_resolve_unit_if.sv
// br_resolve_unit_if: BR request/flag inputs and PC/handshake outputs of the branch resolver
interface br_resolve_unit_if;
  logic        BR_REQ;
  logic [15:0] IR;
  logic        N_IN;
  logic        Z_IN;
  logic        P_IN;
  logic        PC_INC;
  logic [15:0] PC_OUT;
  logic        BEN_OUT;
  logic        BUSY;
  logic        REDIRECT;
  logic        DONE;
  modport slave (
    input  BR_REQ, IR, N_IN, Z_IN, P_IN, PC_INC,
    output PC_OUT, BEN_OUT, BUSY, REDIRECT, DONE
  );
  modport master (
    output BR_REQ, IR, N_IN, Z_IN, P_IN, PC_INC,
    input  PC_OUT, BEN_OUT, BUSY, REDIRECT, DONE
  );
endinterface

// File: rtl/sext_adder.sv
// sext_adder: 16-bit base plus sign-extended OFF_W-bit offset, modulo 2^16
module sext_adder #(
  parameter int OFF_W = 9
) (
  input  logic [15:0]      base_i,
  input  logic [OFF_W-1:0] off_i,
  output logic [15:0]      sum_o
);
  assign sum_o = base_i + 16'($signed(off_i));
endmodule

// File: rtl/br_resolve_unit.sv
// br_resolve_unit: BR evaluate/redirect sequencer owning the PC and BEN registers
module br_resolve_unit
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter int          OFF_W    = 9
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  br_resolve_unit_if.slave   bus
);
  br_state_e        state_q, state_d;
  logic [15:0]      pc_q, pc_d, target;
  logic [2:0]       mask_q, mask_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             ben_q, ben_d;
  logic             unused_ir;
  assign unused_ir = ^bus.IR;
  sext_adder #(.OFF_W(OFF_W)) u_target (
    .base_i (pc_q),
    .off_i  (off_q),
    .sum_o  (target)
  );
  // state, PC, BEN and captured BR fields; reset aborts any operation in flight
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      mask_q  <= '0;
      off_q   <= '0;
      ben_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
      ben_q   <= ben_d;
    end
  end
  // next state: requests only accepted in IDLE, so the PC add in TAKE sees the incremented PC
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    off_d   = off_q;
    ben_d   = ben_q;
    case (state_q)
      IDLE: begin
        pc_d = bus.PC_INC ? pc_q + 16'd1 : pc_q;
        if (bus.BR_REQ) begin
          mask_d  = bus.IR[NZP_HI:NZP_LO];
          off_d   = bus.IR[OFF_W-1:0];
          state_d = EVAL;
        end
      end
      EVAL: begin
        ben_d   = |(mask_q & {bus.N_IN, bus.Z_IN, bus.P_IN});
        state_d = ben_d ? TAKE : FIN;
      end
      TAKE: begin
        pc_d    = target;
        state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.PC_OUT   = pc_q;
  assign bus.BEN_OUT  = ben_q;
  assign bus.BUSY     = state_q != IDLE;
  assign bus.REDIRECT = state_q == TAKE;
  assign bus.DONE     = state_q == FIN;
endmodule

// File: tb/tb_br_resolve_unit.sv
// tb_br_resolve_unit: directed checks of PC increment, branch timing, wrap and busy rejection
module tb_br_resolve_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  br_resolve_unit_if bus_a ();
  br_resolve_unit_if bus_b ();
  br_resolve_unit dut_a (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus_a));
  br_resolve_unit #(.RESET_PC(16'hFFFF)) dut_b (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus_b));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic set_a(input logic [15:0] ir, input logic n, input logic z, input logic p);
    bus_a.IR   = ir;
    bus_a.N_IN = n;
    bus_a.Z_IN = z;
    bus_a.P_IN = p;
  endtask
  initial begin
    rst_n = 1'b0;
    {bus_a.BR_REQ, bus_a.PC_INC, bus_b.BR_REQ, bus_b.PC_INC} = '0;
    set_a(16'h0000, 1'b0, 1'b0, 1'b0);
    bus_b.IR = 16'h0000;
    {bus_b.N_IN, bus_b.Z_IN, bus_b.P_IN} = '0;
    tick();
    tick();
    chk("rst_pc", bus_a.PC_OUT, 16'h3000);
    chk("rst_ben", 16'(bus_a.BEN_OUT), 16'h0);
    chk("rst_busy", 16'(bus_a.BUSY), 16'h0);
    chk("rst_redir", 16'(bus_a.REDIRECT), 16'h0);
    chk("rst_done", 16'(bus_a.DONE), 16'h0);
    rst_n = 1'b1;
    bus_b.PC_INC = 1'b1;
    tick();
    bus_b.PC_INC = 1'b0;
    chk("inc_wrap", bus_b.PC_OUT, 16'h0000);
    bus_b.PC_INC = 1'b1;
    tick();
    tick();
    bus_b.PC_INC = 1'b0;
    chk("inc_to_2", bus_b.PC_OUT, 16'h0002);
    bus_b.IR = 16'h05FC;
    bus_b.Z_IN = 1'b1;
    bus_b.BR_REQ = 1'b1;
    tick();
    bus_b.BR_REQ = 1'b0;
    tick();
    chk("bwd_ben", 16'(bus_b.BEN_OUT), 16'h1);
    chk("bwd_redir", 16'(bus_b.REDIRECT), 16'h1);
    tick();
    chk("bwd_pc", bus_b.PC_OUT, 16'hFFFE);
    chk("bwd_done", 16'(bus_b.DONE), 16'h1);
    bus_a.PC_INC = 1'b1;
    tick();
    bus_a.PC_INC = 1'b0;
    chk("inc_pc", bus_a.PC_OUT, 16'h3001);
    set_a(16'h0E05, 1'b0, 1'b1, 1'b0);
    bus_a.BR_REQ = 1'b1;
    tick();
    bus_a.BR_REQ = 1'b0;
    chk("tk_eval_busy", 16'(bus_a.BUSY), 16'h1);
    chk("tk_eval_redir", 16'(bus_a.REDIRECT), 16'h0);
    tick();
    chk("tk_ben", 16'(bus_a.BEN_OUT), 16'h1);
    chk("tk_redir", 16'(bus_a.REDIRECT), 16'h1);
    chk("tk_pc_hold", bus_a.PC_OUT, 16'h3001);
    chk("tk_done_early", 16'(bus_a.DONE), 16'h0);
    tick();
    chk("tk_pc", bus_a.PC_OUT, 16'h3006);
    chk("tk_done", 16'(bus_a.DONE), 16'h1);
    chk("tk_redir_off", 16'(bus_a.REDIRECT), 16'h0);
    tick();
    chk("tk_idle_busy", 16'(bus_a.BUSY), 16'h0);
    chk("tk_idle_done", 16'(bus_a.DONE), 16'h0);
    set_a(16'h0805, 1'b0, 1'b0, 1'b1);
    bus_a.BR_REQ = 1'b1;
    tick();
    bus_a.BR_REQ = 1'b0;
    tick();
    chk("nt_ben", 16'(bus_a.BEN_OUT), 16'h0);
    chk("nt_done", 16'(bus_a.DONE), 16'h1);
    chk("nt_redir", 16'(bus_a.REDIRECT), 16'h0);
    tick();
    chk("nt_pc", bus_a.PC_OUT, 16'h3006);
    chk("nt_busy", 16'(bus_a.BUSY), 16'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_pc", bus_a.PC_OUT, 16'h3000);
    set_a(16'h0202, 1'b0, 1'b0, 1'b1);
    bus_a.BR_REQ = 1'b1;
    bus_a.PC_INC = 1'b1;
    tick();
    bus_a.BR_REQ = 1'b0;
    bus_a.PC_INC = 1'b0;
    chk("sim_pc_inc", bus_a.PC_OUT, 16'h3001);
    tick();
    chk("sim_ben", 16'(bus_a.BEN_OUT), 16'h1);
    tick();
    chk("sim_pc_tgt", bus_a.PC_OUT, 16'h3003);
    tick();
    set_a(16'h0E05, 1'b0, 1'b1, 1'b0);
    bus_a.BR_REQ = 1'b1;
    tick();
    bus_a.PC_INC = 1'b1;
    tick();
    chk("bsy_pc_take", bus_a.PC_OUT, 16'h3003);
    tick();
    bus_a.BR_REQ = 1'b0;
    bus_a.PC_INC = 1'b0;
    chk("bsy_pc_tgt", bus_a.PC_OUT, 16'h3008);
    tick();
    chk("bsy_idle", 16'(bus_a.BUSY), 16'h0);
    tick();
    chk("bsy_no_second", 16'(bus_a.BUSY), 16'h0);
    chk("bsy_pc_final", bus_a.PC_OUT, 16'h3008);
    set_a(16'h0005, 1'b1, 1'b1, 1'b1);
    bus_a.BR_REQ = 1'b1;
    tick();
    bus_a.BR_REQ = 1'b0;
    tick();
    chk("nop_ben", 16'(bus_a.BEN_OUT), 16'h0);
    chk("nop_done", 16'(bus_a.DONE), 16'h1);
    chk("nop_redir", 16'(bus_a.REDIRECT), 16'h0);
    tick();
    chk("nop_pc", bus_a.PC_OUT, 16'h3008);
    set_a(16'h0E05, 1'b0, 1'b1, 1'b0);
    bus_a.BR_REQ = 1'b1;
    tick();
    bus_a.BR_REQ = 1'b0;
    tick();
    chk("ar_in_take", 16'(bus_a.REDIRECT), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pc_now", bus_a.PC_OUT, 16'h3000);
    chk("ar_busy_now", 16'(bus_a.BUSY), 16'h0);
    chk("ar_redir_now", 16'(bus_a.REDIRECT), 16'h0);
    tick();
    chk("ar_pc_edge", bus_a.PC_OUT, 16'h3000);
    rst_n = 1'b1;
    tick();
    chk("ar_pc_after", bus_a.PC_OUT, 16'h3000);
    chk("ar_busy_after", 16'(bus_a.BUSY), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
